// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream decoder.
// Holds the FSM state encoding and the window/result arithmetic.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } sc_state_t;

    // Window length L = 2**log2.
    function automatic int unsigned sc_win_len(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

    // Bipolar estimate 2*ones - L in 32-bit two's complement.
    function automatic logic [31:0] sc_bipolar_of(
        input logic [31:0] ones,
        input logic [31:0] len
    );
        return (ones << 1) - len;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Sample and ones counters for one decoding window.
// last_sample flags that the next accepted bit closes the window.
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int WIN_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              bit_in,
    output logic [WIN_LOG2:0] ones,
    output logic              last_sample
);

    logic [WIN_LOG2-1:0] sample_cnt;

    // Clear wins over count so a closing bit restarts the window at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (clr) begin
            sample_cnt <= '0;
            ones       <= '0;
        end else if (en) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones       <= ones + {{WIN_LOG2{1'b0}}, bit_in};
        end
    end

    assign last_sample = &sample_cnt;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over L accepted bits.
// Emits a unipolar count or bipolar 2*ones-L through a valid/ready port.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIN_LOG2 = 8,
    parameter bit BIPOLAR  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic                in_bit,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIN_LOG2+1:0] out_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int unsigned L = sc_win_len(WIN_LOG2);
    localparam int OW = WIN_LOG2 + 2;

    sc_state_t         state;
    logic [WIN_LOG2:0] ones;
    logic [WIN_LOG2:0] ones_next;
    logic              last_sample;
    logic              accept;
    logic              done;
    logic              stall_req;
    logic              clr;
    logic [OW-1:0]     result;

    sc_ones_counter #(
        .WIN_LOG2(WIN_LOG2)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (accept),
        .bit_in     (in_bit),
        .ones       (ones),
        .last_sample(last_sample)
    );

    // Hold off the closing bit only while an unconsumed result would be overwritten.
    assign in_ready  = (state == ACCUM)
                     && !(last_sample && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign done      = accept && last_sample;
    assign stall_req = in_valid && last_sample && out_valid && !out_ready;
    assign clr       = ((state == IDLE) && start) || done;
    assign busy      = (state != IDLE);
    assign ones_next = ones + {{WIN_LOG2{1'b0}}, in_bit};

    // Result of the window closing this cycle, including the closing bit.
    always_comb begin
        result = {1'b0, ones_next};
        if (BIPOLAR) begin
            result = OW'(sc_bipolar_of(32'(ones_next), L));
        end
    end

    // Window FSM plus registered result; a load and a consume may share an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_value <= '0;
            out_valid <= 1'b0;
        end else begin
            if (done) begin
                out_value <= result;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) state <= ACCUM;
                end
                ACCUM: begin
                    if (done) state <= cont ? ACCUM : IDLE;
                    else if (stall_req) state <= STALL;
                end
                STALL: begin
                    if (out_ready) state <= ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder, WIN_LOG2=4, unipolar and bipolar copies.
// Window-level model checked every cycle plus literal result lists.
module tb_sc_stream_decoder;

    localparam int WL = 4;
    localparam int L  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready_u, in_ready_b;
    logic       out_valid_u, out_valid_b;
    logic       busy_u, busy_b;
    logic [5:0] out_value_u, out_value_b;

    int checks = 0;
    int failures = 0;

    int  m_cnt = 0;
    int  m_ones = 0;
    int  m_vu = 0;
    int  m_vb = 0;
    bit  m_active = 0;
    bit  m_stalled = 0;
    bit  m_has = 0;
    bit  mb_acc, mb_fin;
    int  mb_nv;

    int  cap_u[$];
    int  cap_b[$];
    int  exp_u[$];
    int  exp_b[$];
    bit  mon_ready = 0;
    int  ready_drops = 0;

    always #5 clk = ~clk;

    sc_stream_decoder #(.WIN_LOG2(WL), .BIPOLAR(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_u),
        .out_value(out_value_u), .out_valid(out_valid_u),
        .out_ready(out_ready), .busy(busy_u)
    );

    sc_stream_decoder #(.WIN_LOG2(WL), .BIPOLAR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_b),
        .out_value(out_value_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_active && !m_stalled
            && !(m_cnt == L - 1 && m_has && !out_ready);
    endfunction

    // Window-level model: accepted bits, ones, one pending result slot.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt = 0; m_ones = 0; m_vu = 0; m_vb = 0;
            m_active = 0; m_stalled = 0; m_has = 0;
        end else begin
            mb_acc = in_valid && m_ready();
            mb_fin = 0;
            mb_nv = 0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_cnt = 0; m_ones = 0;
                end
            end else if (m_stalled) begin
                if (out_ready) m_stalled = 0;
            end else if (mb_acc) begin
                if (m_cnt == L - 1) begin
                    mb_fin = 1;
                    mb_nv = m_ones + int'(in_bit);
                    m_cnt = 0; m_ones = 0;
                    m_active = cont;
                end else begin
                    m_cnt++;
                    m_ones += int'(in_bit);
                end
            end else if (in_valid && m_cnt == L - 1) begin
                m_stalled = 1;
            end
            if (mb_fin) begin
                m_has = 1;
                m_vu = mb_nv;
                m_vb = (2 * mb_nv - L) & 63;
            end else if (out_ready) begin
                m_has = 0;
            end
        end
    end

    // Per-cycle compare and capture of consumed results.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("in_ready_u", int'(in_ready_u), int'(m_ready()));
            chk("in_ready_b", int'(in_ready_b), int'(m_ready()));
            chk("out_valid_u", int'(out_valid_u), int'(m_has));
            chk("out_valid_b", int'(out_valid_b), int'(m_has));
            chk("out_value_u", int'(out_value_u), m_vu);
            chk("out_value_b", int'(out_value_b), m_vb);
            chk("busy_u", int'(busy_u), int'(m_active));
            chk("busy_b", int'(busy_b), int'(m_active));
            if (out_valid_u && out_ready) cap_u.push_back(int'(out_value_u));
            if (out_valid_b && out_ready)
                cap_b.push_back(int'($signed(out_value_b)));
            if (mon_ready && !in_ready_u) ready_drops++;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive(input logic [63:0] bits, input int n,
                         input int duty);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 2000) begin
            in_valid = ($urandom_range(99) < duty);
            in_bit = bits[i];
            @(negedge clk);
            acc = in_valid && in_ready_u;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout: got %0d bits expected %0d", i, n);
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_caps(input string name);
        chk({name, "_n_u"}, cap_u.size(), exp_u.size());
        chk({name, "_n_b"}, cap_b.size(), exp_b.size());
        for (int i = 0; i < exp_u.size() && i < cap_u.size(); i++)
            chk({name, "_u"}, cap_u[i], exp_u[i]);
        for (int i = 0; i < exp_b.size() && i < cap_b.size(); i++)
            chk({name, "_b"}, cap_b[i], exp_b[i]);
        cap_u.delete();
        cap_b.delete();
    endtask

    initial begin
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready_u), 0);
        chk("rst_out_valid", int'(out_valid_u), 0);
        chk("rst_out_value", int'(out_value_b), 0);
        chk("rst_busy", int'(busy_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1011 repeated: 12 ones.
        cont = 1'b0; out_ready = 1'b1;
        do_start();
        drive(64'hBBBB, 16, 100);
        settle();
        exp_u = '{12}; exp_b = '{8};
        chk_caps("t1");
        chk("t1_busy", int'(busy_u), 0);

        // All zeros, all ones, alternating.
        do_start(); drive(64'h0000, 16, 100); settle();
        do_start(); drive(64'hFFFF, 16, 100); settle();
        do_start(); drive(64'hAAAA, 16, 100); settle();
        exp_u = '{0, 16, 8}; exp_b = '{-16, 16, 0};
        chk_caps("t2");

        // Back-to-back windows with 4, 16, 0 ones.
        cont = 1'b1;
        do_start();
        mon_ready = 1;
        drive(64'hFFFF_000F, 32, 100);
        cont = 1'b0;
        drive(64'h0, 16, 100);
        mon_ready = 0;
        settle();
        chk("t3_ready_drops", ready_drops, 0);
        exp_u = '{4, 16, 0}; exp_b = '{-8, 16, -16};
        chk_caps("t3");

        // Backpressure: 8 ones held, second window stalls on bit 16.
        cont = 1'b1; out_ready = 1'b0;
        do_start();
        drive(64'h00FF, 16, 100);
        drive(64'h0001, 15, 100);
        cont = 1'b0;
        in_valid = 1'b1; in_bit = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_ready", int'(in_ready_u), 0);
            chk("t4_hold_value", int'(out_value_u), 8);
            chk("t4_hold_valid", int'(out_valid_u), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(64'h1, 1, 100);
        settle();
        exp_u = '{8, 2}; exp_b = '{0, -12};
        chk_caps("t4");

        // Sparse valid, 7 ones.
        do_start();
        drive(64'h007F, 16, 30);
        settle();
        exp_u = '{7}; exp_b = '{-2};
        chk_caps("t5");

        // Reset mid-window after 9 bits, then a clean 5-ones window.
        do_start();
        drive(64'h01FF, 9, 100);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ready", int'(in_ready_u), 0);
        chk("t6_rst_busy", int'(busy_u), 0);
        chk("t6_rst_valid", int'(out_valid_b), 0);
        chk("t6_rst_value", int'(out_value_u), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        drive(64'h001F, 16, 100);
        settle();
        exp_u = '{5}; exp_b = '{-6};
        chk_caps("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
